// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serializer: start, LSB-first data, optional parity, stop
//
// Ports:
//   CLK        TX bit clock, one serial bit per rising edge
//   RST        asynchronous active-high reset
//   P_DATA     parallel byte to send, sampled on the accept edge
//   Data_Valid send request, honoured only in IDLE or STOP
//   PAR_EN     append parity bit, sampled on the accept edge
//   PAR_TYP    0 even / 1 odd parity, sampled on the accept edge
//   TX_OUT     registered serial line, idles high
//   Busy       registered, high while a frame occupies the line
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  // A new frame can only be taken when the line is idle or finishing its stop bit.
  assign accept = Data_Valid && ((state_q == S_IDLE) || (state_q == S_STOP));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  state_d = S_DATA;
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = accept ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (accept) begin
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
      cnt_d     = '0;
    end

    // Outputs are registered, so they are derived from the state being entered.
    // In DATA the shift register's LSB is the bit for the coming cycle; shifting
    // as it is consumed keeps the next bit in position 0.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA: begin
        tx_d   = data_q[0];
        data_d = data_q >> 1;
      end
      S_PARITY: tx_d = par_bit_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - randomized self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks;
  int failures;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    chk({tag, " tx"}, 32'(TX_OUT), 32'd1);
    chk({tag, " busy"}, 32'(Busy), 32'd0);
  endtask

  // Present a request at a falling edge; the following rising edge accepts it.
  task automatic request(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    Data_Valid = 1'b1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
  endtask

  // Reference line sequence: start 0, data LSB first, optional parity, stop 1.
  // After each sample the inputs are scrambled, a stray request may be pulsed
  // mid-frame, and optionally the next frame is requested in the stop cycle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                           input bit chain, input logic [7:0] nd, input logic npe, input logic npt,
                           input int noise_at, input int abort_at);
    logic exp_bits [$];
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(d[k]);
    if (pe) exp_bits.push_back((^d) ^ pt);
    exp_bits.push_back(1'b1);
    for (int i = 0; i < exp_bits.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx bit%0d", name, i), 32'(TX_OUT), 32'(exp_bits[i]));
      chk($sformatf("%s busy bit%0d", name, i), 32'(Busy), 32'd1);
      if (i == abort_at) begin
        #2 RST = 1'b1;
        #1;
        chk({name, " abort tx"}, 32'(TX_OUT), 32'd1);
        chk({name, " abort busy"}, 32'(Busy), 32'd0);
        Data_Valid = 1'b0;
        return;
      end
      Data_Valid = 1'b0;
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      if (i == noise_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
      end
      if (chain && i == exp_bits.size() - 1) begin
        Data_Valid = 1'b1;
        P_DATA     = nd;
        PAR_EN     = npe;
        PAR_TYP    = npt;
      end
    end
  endtask

  initial begin
    logic [7:0] d, nd;
    logic       pe, pt, npe, npt;
    bit         chain;
    int         len;
    int         noise;

    checks     = 0;
    failures   = 0;
    RST        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    @(negedge CLK);
    chk("reset tx", 32'(TX_OUT), 32'd1);
    chk("reset busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    check_idle("post reset");

    request(8'hA5, 1'b0, 1'b0);
    run_frame("a5 nopar", 8'hA5, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("a5 nopar end");

    request(8'hA5, 1'b1, 1'b0);
    run_frame("a5 even", 8'hA5, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("a5 even end");

    request(8'hA5, 1'b1, 1'b1);
    run_frame("a5 odd", 8'hA5, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("a5 odd end");

    request(8'h01, 1'b1, 1'b0);
    run_frame("01 even", 8'h01, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("01 even end");

    request(8'h00, 1'b1, 1'b1);
    run_frame("00 odd", 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("00 odd end");

    request(8'h3C, 1'b0, 1'b0);
    run_frame("b2b 3c", 8'h3C, 1'b0, 1'b0, 1, 8'hC3, 1'b0, 1'b0, -1, -1);
    run_frame("b2b c3", 8'hC3, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("b2b end");

    request(8'h0F, 1'b0, 1'b0);
    run_frame("midreq 0f", 8'h0F, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 3, -1);
    check_idle("midreq end");

    request(8'h55, 1'b0, 1'b0);
    run_frame("abort 55", 8'h55, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, -1, 4);
    @(negedge CLK);
    chk("in reset tx", 32'(TX_OUT), 32'd1);
    chk("in reset busy", 32'(Busy), 32'd0);
    RST = 1'b0;
    request(8'h81, 1'b0, 1'b0);
    run_frame("after abort 81", 8'h81, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("after abort end");

    @(negedge CLK);
    RST        = 1'b1;
    Data_Valid = 1'b1;
    P_DATA     = 8'hAA;
    @(negedge CLK);
    RST        = 1'b0;
    Data_Valid = 1'b0;
    check_idle("rst vs valid 1");
    check_idle("rst vs valid 2");

    d     = 8'($urandom);
    pe    = 1'($urandom);
    pt    = 1'($urandom);
    chain = 0;
    request(d, pe, pt);
    for (int f = 0; f < 40; f++) begin
      nd    = 8'($urandom);
      npe   = 1'($urandom);
      npt   = 1'($urandom);
      chain = ($urandom_range(0, 1) == 1);
      len   = pe ? 11 : 10;
      noise = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 2) : -1;
      run_frame($sformatf("rnd%0d", f), d, pe, pt, chain, nd, npe, npt, noise, -1);
      if (!chain) begin
        check_idle($sformatf("rnd%0d end", f));
        request(nd, npe, npt);
      end
      d  = nd;
      pe = npe;
      pt = npt;
    end
    run_frame("rnd last", d, pe, pt, 0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_idle("rnd last end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
